// File: rtl/cell_probe_pkg.sv
// Shared encodings for the cell probe timer: command opcodes and FSM states.
package cell_probe_pkg;

    typedef enum logic [1:0] {
        OP_SET_CH   = 2'b00,
        OP_SET_GATE = 2'b01,
        OP_START    = 2'b10,
        OP_ABORT    = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/probe_sync_edge.sv
// Brings an asynchronous probe into the clk domain and flags its rising edges.
module probe_sync_edge #(
    parameter int unsigned SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STG-1:0] r_sync;
    logic                r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], i_sig};
            r_prev <= r_sync[SYNC_STG-1];
        end
    end

    assign o_level = r_sync[SYNC_STG-1];
    assign o_rise  = r_sync[SYNC_STG-1] & ~r_prev;

endmodule

// File: rtl/cell_probe_timer.sv
// Multi-channel edge-count timer: picks one probe, synchronises it and counts its
// rising edges over a programmable gate window into a saturating, byte-readable count.
module cell_probe_timer
    import cell_probe_pkg::*;
#(
    parameter int unsigned N_CH     = 8,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned GATE_W   = 12,
    parameter int unsigned GATE_DEF = 256,
    parameter int unsigned SYNC_STG = 2,
    localparam int unsigned N_BYTES = CNT_W / 8,
    localparam int unsigned RS_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   i_sig,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd_op,
    input  logic [GATE_W-1:0] i_cmd_data,
    input  logic [RS_W-1:0]   i_rd_sel,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic              o_cmd_err,
    output logic [CNT_W-1:0]  o_count,
    output logic [7:0]        o_rd_byte
);

    localparam int unsigned CH_W  = $clog2(N_CH);
    localparam int unsigned SET_W = $clog2(SYNC_STG + 2);
    localparam int unsigned TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            r_state;
    logic [CH_W-1:0]   r_ch;
    logic [GATE_W-1:0] r_gate;
    logic [TMR_W-1:0]  r_tmr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_busy;
    logic              r_done;
    logic              r_cmd_err;

    cmd_op_e w_op;
    logic    w_probe;
    logic    w_rise;
    logic    w_level_unused;
    logic    w_ch_ok;
    logic    w_gate_ok;
    logic    w_abort;

    assign w_op      = cmd_op_e'(i_cmd_op);
    assign w_probe   = i_sig[r_ch];
    assign w_ch_ok   = i_cmd_data < GATE_W'(N_CH);
    assign w_gate_ok = i_cmd_data != '0;
    assign w_abort   = i_cmd_valid && (w_op == OP_ABORT);

    // Single synchroniser after the mux; SETTLE flushes it after a channel change.
    probe_sync_edge #(
        .SYNC_STG (SYNC_STG)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sig   (w_probe),
        .o_level (w_level_unused),
        .o_rise  (w_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ch       <= '0;
            r_gate     <= GATE_W'(GATE_DEF);
            r_tmr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (i_cmd_valid) begin
                        unique case (w_op)
                            OP_SET_CH: begin
                                if (r_state == ST_IDLE && w_ch_ok) r_ch <= i_cmd_data[CH_W-1:0];
                                else r_cmd_err <= 1'b1;
                            end
                            OP_SET_GATE: begin
                                if (r_state == ST_IDLE && w_gate_ok) r_gate <= i_cmd_data;
                                else r_cmd_err <= 1'b1;
                            end
                            OP_START: begin
                                r_state    <= ST_SETTLE;
                                r_busy     <= 1'b1;
                                r_tmr      <= TMR_W'(SYNC_STG);
                                r_count    <= '0;
                                r_overflow <= 1'b0;
                            end
                            OP_ABORT: ;
                        endcase
                    end
                end
                ST_SETTLE, ST_GATE: begin
                    // ABORT wins over a same-cycle edge or gate expiry.
                    if (w_abort) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end else begin
                        r_cmd_err <= i_cmd_valid;
                        if (r_state == ST_SETTLE) begin
                            if (r_tmr == '0) begin
                                r_state <= ST_GATE;
                                r_tmr   <= TMR_W'(r_gate) - TMR_W'(1);
                            end else begin
                                r_tmr <= r_tmr - TMR_W'(1);
                            end
                        end else begin
                            if (w_rise) begin
                                if (r_count == CNT_MAX) r_overflow <= 1'b1;
                                else r_count <= r_count + CNT_W'(1);
                            end
                            if (r_tmr == '0) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_tmr <= r_tmr - TMR_W'(1);
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_rd_byte = 8'h00;
        for (int b = 0; b < N_BYTES; b++) begin
            if (i_rd_sel == RS_W'(b)) o_rd_byte = r_count[8*b +: 8];
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_overflow = r_overflow;
    assign o_cmd_err  = r_cmd_err;
    assign o_count    = r_count;

endmodule
